// File: rtl/td4_pkg.sv
// td4_pkg: state encoding, adder source codes, opcodes and decode record for the TD4 controller.
package td4_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;
  localparam logic [3:0] OP_ADD_A = 4'h0;
  localparam logic [3:0] OP_MOV_AB = 4'h1;
  localparam logic [3:0] OP_IN_A  = 4'h2;
  localparam logic [3:0] OP_MOV_AI = 4'h3;
  localparam logic [3:0] OP_MOV_BA = 4'h4;
  localparam logic [3:0] OP_ADD_B = 4'h5;
  localparam logic [3:0] OP_IN_B  = 4'h6;
  localparam logic [3:0] OP_MOV_BI = 4'h7;
  localparam logic [3:0] OP_HLT   = 4'h8;
  localparam logic [3:0] OP_OUT_B = 4'h9;
  localparam logic [3:0] OP_OUT_I = 4'hB;
  localparam logic [3:0] OP_JNC   = 4'hE;
  localparam logic [3:0] OP_JMP   = 4'hF;
  typedef struct packed {
    logic [1:0] sel;
    logic       load_a;
    logic       load_b;
    logic       load_out;
    logic       load_pc;
    logic       hlt;
  } dec_t;
endpackage

// File: rtl/td4_decode.sv
// td4_decode: opcode -> adder source and register load, pure combinational.
// TD4_HALT_DETECT_EN makes opcode 8 a halt; otherwise it falls through as a NOP.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       c_flag_i,
  output dec_t       dec_o
);
  always_comb begin
    dec_o = '0;
    dec_o.sel = SEL_ZERO;
    case (op_i)
      OP_ADD_A:  begin dec_o.sel = SEL_A;  dec_o.load_a = 1'b1; end
      OP_MOV_AB: begin dec_o.sel = SEL_B;  dec_o.load_a = 1'b1; end
      OP_IN_A:   begin dec_o.sel = SEL_IN; dec_o.load_a = 1'b1; end
      OP_MOV_AI: dec_o.load_a = 1'b1;
      OP_MOV_BA: begin dec_o.sel = SEL_A;  dec_o.load_b = 1'b1; end
      OP_ADD_B:  begin dec_o.sel = SEL_B;  dec_o.load_b = 1'b1; end
      OP_IN_B:   begin dec_o.sel = SEL_IN; dec_o.load_b = 1'b1; end
      OP_MOV_BI: dec_o.load_b = 1'b1;
      OP_OUT_B:  begin dec_o.sel = SEL_B;  dec_o.load_out = 1'b1; end
      OP_OUT_I:  dec_o.load_out = 1'b1;
      OP_JMP:    dec_o.load_pc = 1'b1;
      OP_JNC:    dec_o.load_pc = ~c_flag_i;
`ifdef TD4_HALT_DETECT_EN
      OP_HLT:    dec_o.hlt = 1'b1;
`endif
      default:   ;
    endcase
  end
endmodule

// File: rtl/td4_control.sv
// td4_control: TD4 two-phase (FETCH/EXEC) sequencer holding IR and the carry flag.
// TD4_HALT_DETECT_EN enables the HALT state reached by opcode 8.
module td4_control
  import td4_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       EN,
  input  logic [7:0] INSTR,
  input  logic       ALU_CARRY,
  output logic       LOAD_A,
  output logic       LOAD_B,
  output logic       LOAD_OUT,
  output logic       LOAD_PC,
  output logic       REG_EN,
  output logic [1:0] SEL,
  output logic [3:0] IM,
  output logic       C_FLAG,
  output logic [1:0] PHASE,
  output logic       HALTED
);
  logic [1:0] state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       c_q, c_d;
  logic       exec;
  dec_t       dec;
  td4_decode u_dec (.op_i(ir_q[7:4]), .c_flag_i(c_q), .dec_o(dec));
  assign exec = state_q == ST_EXEC;
  always_comb begin
    state_d = state_q == ST_IDLE  ? (EN ? ST_FETCH : ST_IDLE)
            : state_q == ST_FETCH ? ST_EXEC
            : state_q == ST_EXEC  ? (dec.hlt ? ST_HALT : EN ? ST_FETCH : ST_IDLE)
            : ST_HALT;
    ir_d = state_q == ST_FETCH ? INSTR : ir_q;
    c_d = exec ? ALU_CARRY : c_q;
  end
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      state_q <= ST_IDLE;
      ir_q <= '0;
      c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      c_q <= c_d;
    end
  // every control output is a pure function of state, so reset clears them at once
  assign LOAD_A = exec & dec.load_a;
  assign LOAD_B = exec & dec.load_b;
  assign LOAD_OUT = exec & dec.load_out;
  assign LOAD_PC = exec & dec.load_pc;
  assign REG_EN = exec & ~dec.hlt;
  assign SEL = exec ? dec.sel : 2'b00;
  assign IM = exec ? ir_q[3:0] : 4'h0;
  assign C_FLAG = c_q;
  assign PHASE = state_q;
`ifdef TD4_HALT_DETECT_EN
  assign HALTED = state_q == ST_HALT;
`else
  assign HALTED = 1'b0;
`endif
endmodule

// File: tb/tb_td4_control.sv
// tb_td4_control: table vectors, hand sequences and random run against an instruction-level model.
module tb_td4_control;
`ifdef TD4_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam int K_NONE = 0, K_A = 1, K_B = 2, K_OUT = 3, K_PC = 4, K_JNC = 5, K_HLT = 6;
  logic CLK = 1'b0, CLR = 1'b0, EN = 1'b0, ALU_CARRY = 1'b0;
  logic [7:0] INSTR = 8'h00;
  logic LOAD_A, LOAD_B, LOAD_OUT, LOAD_PC, REG_EN, C_FLAG, HALTED;
  logic [1:0] SEL, PHASE;
  logic [3:0] IM;
  int total = 0, bad = 0;
  int m_phase = 0;
  logic [7:0] m_ir = 8'h00;
  logic m_c = 1'b0;
  int kind_tab [16] = '{K_A, K_A, K_A, K_A, K_B, K_B, K_B, K_B,
                        K_HLT, K_OUT, K_NONE, K_OUT, K_NONE, K_NONE, K_JNC, K_PC};
  logic [1:0] sel_tab [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                               2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
  typedef struct {
    logic [7:0] instr;
    logic       cy;
    logic [1:0] sel;
    logic [3:0] ld;
    logic       c;
  } vec_t;
  vec_t tbl [15];
  td4_control dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .INSTR(INSTR), .ALU_CARRY(ALU_CARRY),
    .LOAD_A(LOAD_A), .LOAD_B(LOAD_B), .LOAD_OUT(LOAD_OUT), .LOAD_PC(LOAD_PC),
    .REG_EN(REG_EN), .SEL(SEL), .IM(IM), .C_FLAG(C_FLAG), .PHASE(PHASE), .HALTED(HALTED)
  );
  always #5 CLK = ~CLK;
  function automatic logic [14:0] dut_vec();
    return {PHASE, HALTED, REG_EN, LOAD_A, LOAD_B, LOAD_OUT, LOAD_PC, SEL, IM, C_FLAG};
  endfunction
  function automatic logic [14:0] model_vec();
    logic [3:0] op = m_ir[7:4];
    int k = kind_tab[op];
    logic [14:0] r;
    if (k == K_HLT && !HALT_EN) k = K_NONE;
    r = {m_phase[1:0], m_phase == 3, 11'b0, m_c};
    if (m_phase == 2)
      r[12:1] = {k != K_HLT, k == K_A, k == K_B, k == K_OUT,
                 k == K_PC || (k == K_JNC && !m_c), sel_tab[op], m_ir[3:0]};
    return r;
  endfunction
  task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic tick(input string name);
    logic en = EN, cy = ALU_CARRY;
    logic [7:0] ins = INSTR;
    @(posedge CLK);
    if (!CLR) begin
      m_phase = 0; m_ir = '0; m_c = 1'b0;
    end else if (m_phase == 0) m_phase = en ? 1 : 0;
    else if (m_phase == 1) begin m_ir = ins; m_phase = 2; end
    else if (m_phase == 2) begin
      m_c = cy;
      m_phase = (HALT_EN && m_ir[7:4] == 4'h8) ? 3 : en ? 1 : 0;
    end
    #1;
    chk(name, dut_vec(), model_vec());
  endtask
  task automatic assert_clr(input string name);
    CLR = 1'b0;
    m_phase = 0; m_ir = '0; m_c = 1'b0;
    #1;
    chk(name, dut_vec(), 15'h0);
  endtask
  initial begin
    tbl[0]  = '{8'h35, 1'b0, 2'd3, 4'b1000, 1'b0};
    tbl[1]  = '{8'h0F, 1'b1, 2'd0, 4'b1000, 1'b1};
    tbl[2]  = '{8'hE7, 1'b0, 2'd3, 4'b0000, 1'b0};
    tbl[3]  = '{8'hE7, 1'b0, 2'd3, 4'b0001, 1'b0};
    tbl[4]  = '{8'hB9, 1'b0, 2'd3, 4'b0010, 1'b0};
    tbl[5]  = '{8'h90, 1'b0, 2'd1, 4'b0010, 1'b0};
    tbl[6]  = '{8'h52, 1'b1, 2'd1, 4'b0100, 1'b1};
    tbl[7]  = '{8'h7A, 1'b0, 2'd3, 4'b0100, 1'b0};
    tbl[8]  = '{8'h13, 1'b0, 2'd1, 4'b1000, 1'b0};
    tbl[9]  = '{8'h44, 1'b0, 2'd0, 4'b0100, 1'b0};
    tbl[10] = '{8'h2C, 1'b1, 2'd2, 4'b1000, 1'b1};
    tbl[11] = '{8'h61, 1'b0, 2'd2, 4'b0100, 1'b0};
    tbl[12] = '{8'hFD, 1'b0, 2'd3, 4'b0001, 1'b0};
    tbl[13] = '{8'hC6, 1'b1, 2'd3, 4'b0000, 1'b1};
    tbl[14] = '{8'hA0, 1'b0, 2'd3, 4'b0000, 1'b0};
    #1;
    chk("reset_state", dut_vec(), 15'h0);
    tick("in_reset");
    @(negedge CLK);
    CLR = 1'b1;
    for (int i = 0; i < 3; i++) tick("idle_wait");
    chk("idle_no_en", {13'b0, PHASE}, 15'd0);
    EN = 1'b1;
    tick("first_fetch");
    chk("first_fetch_phase", {13'b0, PHASE}, 15'd1);
    for (int i = 0; i < 15; i++) begin
      INSTR = tbl[i].instr;
      tick("tbl_fetch");
      chk("tbl_exec", {4'b0, REG_EN, SEL, LOAD_A, LOAD_B, LOAD_OUT, LOAD_PC, IM},
          {4'b0, 1'b1, tbl[i].sel, tbl[i].ld, tbl[i].instr[3:0]});
      ALU_CARRY = tbl[i].cy;
      INSTR = $urandom;
      tick("tbl_next");
      chk("tbl_cflag", {14'b0, C_FLAG}, {14'b0, tbl[i].c});
    end
    INSTR = 8'h35;
    EN = 1'b0;
    tick("endrop_exec");
    chk("endrop_exec_phase", {12'b0, REG_EN, PHASE}, {12'b0, 1'b1, 2'd2});
    tick("endrop_idle");
    chk("endrop_idle_phase", {12'b0, REG_EN, PHASE}, 15'd0);
    for (int i = 0; i < 3; i++) begin
      tick("endrop_hold");
      chk("endrop_no_regen", {14'b0, REG_EN}, 15'd0);
    end
    EN = 1'b1;
    tick("endrop_resume");
    INSTR = 8'h35;
    tick("clr_exec");
    chk("clr_pre_exec", {13'b0, PHASE}, 15'd2);
    #2;
    assert_clr("clr_mid_exec");
    @(negedge CLK);
    CLR = 1'b1;
    tick("clr_release");
    chk("clr_release_phase", {13'b0, PHASE}, 15'd1);
    INSTR = 8'h80;
    tick("hlt_exec");
    for (int i = 0; i < 10; i++) tick("hlt_after");
    #2;
    assert_clr("hlt_clear");
    @(negedge CLK);
    CLR = 1'b1;
    for (int i = 0; i < 400; i++) begin
      EN = $urandom_range(0, 3) != 0;
      INSTR = $urandom;
      if (INSTR[7:4] == 4'h8) INSTR[7:4] = 4'hD;
      ALU_CARRY = $urandom;
      tick("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/td4_control.md
TD4_CONTROL -- requirements
Module: td4_control

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single system clock; all state changes on the rising edge.
REQ-002 SHALL have port CLR, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port EN, input, 1 bit: run enable, sampled in IDLE and EXEC.
REQ-004 SHALL have port INSTR, input, 8 bits: instruction byte from program ROM; [7:4] opcode, [3:0] immediate.
REQ-005 SHALL have port ALU_CARRY, input, 1 bit: carry-out of the 4-bit adder.
REQ-006 SHALL have ports LOAD_A, LOAD_B, LOAD_OUT, LOAD_PC, output, 1 bit each: active-high register load selects.
REQ-007 SHALL have port REG_EN, output, 1 bit: register clock-enable; high exactly one cycle per instruction.
REQ-008 SHALL have port SEL, output, 2 bits: adder source; 00 A, 01 B, 10 IN port, 11 zero.
REQ-009 SHALL have port IM, output, 4 bits: immediate operand, equal to IR[3:0].
REQ-010 SHALL have port C_FLAG, output, 1 bit: registered carry flag.
REQ-011 SHALL have port PHASE, output, 2 bits: current state; IDLE=0, FETCH=1, EXEC=2, HALT=3.
REQ-012 SHALL have port HALTED, output, 1 bit: high while in HALT.

Function
REQ-013 SHALL implement states IDLE, FETCH, EXEC and HALT; two cycles per instruction (FETCH, then EXEC).
REQ-014 Transitions SHALL be: IDLE->FETCH when EN=1, otherwise stay; FETCH->EXEC unconditionally; EXEC->FETCH when EN=1, otherwise EXEC->IDLE.
REQ-015 At the FETCH clock edge, INSTR SHALL be latched into an 8-bit IR; INSTR SHALL be ignored in all other states.
REQ-016 REG_EN, the LOAD_* outputs, and non-zero SEL/IM SHALL be driven only in EXEC, decoded from IR; elsewhere all are 0.
REQ-017 Decode SHALL follow opcode -> (SEL, load), with IM = IR[3:0] in every row:
- 0000 ADD A,Im -> (A, LOAD_A); 0101 ADD B,Im -> (B, LOAD_B)
- 0011 MOV A,Im -> (zero, LOAD_A); 0111 MOV B,Im -> (zero, LOAD_B)
- 0001 MOV A,B -> (B, LOAD_A); 0100 MOV B,A -> (A, LOAD_B)
- 0010 IN A -> (IN, LOAD_A); 0110 IN B -> (IN, LOAD_B)
- 1001 OUT B -> (B, LOAD_OUT); 1011 OUT Im -> (zero, LOAD_OUT)
- 1111 JMP -> (zero, LOAD_PC)
- 1110 JNC -> (zero, LOAD_PC only if C_FLAG=0)
REQ-018 Any other opcode SHALL be a NOP: SEL=11, no LOAD_*, REG_EN still 1 so PC increments.
REQ-019 When LOAD_PC=0 in EXEC, PC SHALL advance by one via REG_EN; at most one LOAD_* SHALL be high in any cycle.
REQ-020 C_FLAG SHALL take ALU_CARRY at every EXEC edge, including jumps (zero+Im yields carry 0); JNC SHALL test the pre-edge C_FLAG value.
REQ-021 EN falling during FETCH SHALL NOT abort the instruction; EXEC completes, then IDLE.

Reset
REQ-022 CLR=0 SHALL asynchronously force PHASE=IDLE, IR=0, C_FLAG=0, and all LOAD_*, REG_EN, SEL, IM and HALTED to 0, including mid-EXEC.
REQ-023 After CLR rises, the first FETCH SHALL occur on the first edge with EN=1.

Configuration
REQ-024 Macro TD4_HALT_DETECT_EN defined: opcode 1000 SHALL be HLT; its EXEC asserts REG_EN=0 and enters HALT; HALT is left only by CLR; HALTED=1 in HALT.
REQ-025 Macro TD4_HALT_DETECT_EN undefined: opcode 1000 SHALL be a NOP, HALT SHALL be unreachable, and HALTED SHALL be tied 0.

Structure
REQ-026 Package td4_pkg SHALL hold opcode constants, SEL codes and the state encoding.
REQ-027 A combinational sub-module td4_decode (IR, C_FLAG -> SEL, LOAD_*) SHALL contain the decode table; td4_control holds the FSM, IR and C_FLAG.

Verification
REQ-028 CLR=0 mid-EXEC -> all outputs 0 immediately; CLR=1 with EN=1 -> PHASE=1 after one edge.
REQ-029 INSTR=8'h35 -> in EXEC SEL=11, IM=5, LOAD_A=1, REG_EN=1 for exactly one cycle.
REQ-030 8'h0F with ALU_CARRY=1, then 8'hE7 -> LOAD_PC=0 (no jump), C_FLAG becomes 0; a second 8'hE7 -> LOAD_PC=1, IM=7.
REQ-031 8'hB9 -> SEL=11, IM=9, LOAD_OUT=1; 8'h90 -> SEL=01, LOAD_OUT=1.
REQ-032 EN=0 applied during FETCH -> EXEC completes, PHASE=0 next, no further REG_EN until EN=1.
REQ-033 8'h80 -> with TD4_HALT_DETECT_EN: HALTED=1, PHASE=3, REG_EN stays 0 for 10 cycles; without it: NOP, REG_EN=1, PHASE returns to 1.
